// File: rtl/midi_msg_parser_if.sv
`default_nettype none
// ============================================================================
// midi_msg_parser_if : byte input and decoded-event output bundle
// Rev 1.0
// ============================================================================
interface midi_msg_parser_if;
   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       evt_ready;
   logic       evt_valid;
   logic [2:0] evt_type;
   logic [3:0] evt_chan;
   logic [6:0] evt_d1;
   logic [6:0] evt_d2;
   logic       overflow;

   modport master (
      output rx_byte, rx_valid, evt_ready,
      input  evt_valid, evt_type, evt_chan, evt_d1, evt_d2, overflow
   );

   modport slave (
      input  rx_byte, rx_valid, evt_ready,
      output evt_valid, evt_type, evt_chan, evt_d1, evt_d2, overflow
   );
endinterface
`default_nettype wire

// File: rtl/midi_msg_parser.sv
`default_nettype none
// ============================================================================
// midi_msg_parser : MIDI channel-voice parser with running status and a
//                   single-entry event output register
// Rev 1.0
// ============================================================================
module midi_msg_parser (
   input  wire logic          clk,
   input  wire logic          rst,
   midi_msg_parser_if.slave   bus
);
   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_WAIT_D1 = 2'd1;
   localparam logic [1:0] S_WAIT_D2 = 2'd2;
   localparam logic [1:0] S_SYSEX   = 2'd3;

   logic [1:0] r_state, w_state_nxt;
   logic [7:0] r_status, w_status_nxt;
   logic [6:0] r_d1, w_d1_nxt;

   logic       w_complete;
   logic [6:0] w_d2_fin;
   logic [6:0] w_ev_d1;
   logic [2:0] w_ev_type;
   logic       w_load;
   logic       w_drop;

   logic       r_evt_valid;
   logic [2:0] r_evt_type;
   logic [3:0] r_evt_chan;
   logic [6:0] r_evt_d1;
   logic [6:0] r_evt_d2;
   logic       r_overflow;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_status    <= 8'd0;
         r_d1        <= 7'd0;
         r_evt_valid <= 1'b0;
         r_evt_type  <= 3'd0;
         r_evt_chan  <= 4'd0;
         r_evt_d1    <= 7'd0;
         r_evt_d2    <= 7'd0;
         r_overflow  <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_status <= w_status_nxt;
         r_d1     <= w_d1_nxt;
         if (w_load) begin
            r_evt_valid <= 1'b1;
            r_evt_type  <= w_ev_type;
            r_evt_chan  <= r_status[3:0];
            r_evt_d1    <= w_ev_d1;
            r_evt_d2    <= w_d2_fin;
         end else if (r_evt_valid && bus.evt_ready) begin
            r_evt_valid <= 1'b0;
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // Real-time bytes (0xF8-0xFF) fall through every branch untouched.
   always_comb begin
      w_state_nxt  = r_state;
      w_status_nxt = r_status;
      w_d1_nxt     = r_d1;
      w_complete   = 1'b0;
      w_d2_fin     = 7'd0;
      if (bus.rx_valid) begin
         if (bus.rx_byte[7]) begin
            if (bus.rx_byte < 8'hF0) begin
               w_status_nxt = bus.rx_byte;
               w_state_nxt  = S_WAIT_D1;
            end else if (bus.rx_byte == 8'hF0) begin
               w_status_nxt = 8'd0;
               w_state_nxt  = S_SYSEX;
            end else if (bus.rx_byte <= 8'hF7) begin
               w_status_nxt = 8'd0;
               w_state_nxt  = S_IDLE;
            end
         end else begin
            case (r_state)
               S_WAIT_D1: begin
                  w_d1_nxt = bus.rx_byte[6:0];
                  if (r_status[6:5] == 2'b10) begin
                     w_complete = 1'b1;
                  end else begin
                     w_state_nxt = S_WAIT_D2;
                  end
               end
               S_WAIT_D2: begin
                  w_complete  = 1'b1;
                  w_d2_fin    = bus.rx_byte[6:0];
                  w_state_nxt = S_WAIT_D1;
               end
               default: ;
            endcase
         end
      end
   end

   // One-data-byte messages complete in WAIT_D1, so d1 is the byte in flight.
   always_comb begin
      w_ev_d1   = (r_state == S_WAIT_D1) ? bus.rx_byte[6:0] : r_d1;
      w_ev_type = r_status[6:4];
      if (w_ev_type == 3'd1 && w_d2_fin == 7'd0) begin
         w_ev_type = 3'd0;
      end
      w_load = w_complete && (!r_evt_valid || bus.evt_ready);
      w_drop = w_complete && r_evt_valid && !bus.evt_ready;
   end

   assign bus.evt_valid = r_evt_valid;
   assign bus.evt_type  = r_evt_type;
   assign bus.evt_chan  = r_evt_chan;
   assign bus.evt_d1    = r_evt_d1;
   assign bus.evt_d2    = r_evt_d2;
   assign bus.overflow  = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_midi_msg_parser.sv
`default_nettype none
// ============================================================================
// tb_midi_msg_parser : directed and random byte streams against a message-level
//                      reference model
// Rev 1.0
// ============================================================================
module tb_midi_msg_parser;
   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   midi_msg_parser_if bus ();

   midi_msg_parser dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference model: running status plus a list of collected data bytes.
   logic [7:0] m_status;
   logic [7:0] m_q[$];
   bit         m_valid;
   logic [2:0] m_type;
   logic [3:0] m_chan;
   logic [6:0] m_d1;
   logic [6:0] m_d2;
   bit         m_ovf;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic model_update(input bit rv, input logic [7:0] rb, input bit rdy, input bit rs);
      bit         emit;
      int         need;
      logic [2:0] e_type;
      logic [6:0] e_d1, e_d2;
      emit = 0;
      e_type = 0; e_d1 = 0; e_d2 = 0;
      if (rs) begin
         m_status = 0; m_q.delete();
         m_valid = 0; m_type = 0; m_chan = 0; m_d1 = 0; m_d2 = 0; m_ovf = 0;
         return;
      end
      if (rv) begin
         if (rb >= 8'hF8) begin
         end else if (rb >= 8'hF0) begin
            m_status = 0; m_q.delete();
         end else if (rb >= 8'h80) begin
            m_status = rb; m_q.delete();
         end else if (m_status != 0) begin
            m_q.push_back(rb);
            need = (m_status >= 8'hC0 && m_status <= 8'hDF) ? 1 : 2;
            if (m_q.size() == need) begin
               emit   = 1;
               e_d1   = m_q[0][6:0];
               e_d2   = (need == 2) ? m_q[1][6:0] : 7'd0;
               e_type = 3'((m_status >> 4) - 8);
               if (e_type == 3'd1 && e_d2 == 0) e_type = 3'd0;
               m_q.delete();
            end
         end
      end
      if (emit && (!m_valid || rdy)) begin
         m_valid = 1; m_type = e_type; m_chan = m_status[3:0]; m_d1 = e_d1; m_d2 = e_d2;
      end else begin
         if (emit) m_ovf = 1;
         if (m_valid && rdy) m_valid = 0;
      end
   endtask

   task automatic compare_all();
      chk("valid", bus.evt_valid, m_valid);
      chk("type",  bus.evt_type,  m_type);
      chk("chan",  bus.evt_chan,  m_chan);
      chk("d1",    bus.evt_d1,    m_d1);
      chk("d2",    bus.evt_d2,    m_d2);
      chk("ovf",   bus.overflow,  m_ovf);
   endtask

   // Called at a negedge; inputs held through the next posedge, outputs compared at the following negedge.
   task automatic step(input bit rv, input logic [7:0] rb, input bit rdy, input bit rs);
      bus.rx_valid  = rv;
      bus.rx_byte   = rb;
      bus.evt_ready = rdy;
      rst           = rs;
      @(posedge clk);
      model_update(rv, rb, rdy, rs);
      @(negedge clk);
      compare_all();
   endtask

   task automatic send(input logic [7:0] b, input bit rdy);
      step(1'b1, b, rdy, 1'b0);
   endtask

   task automatic chk_evt(input string tag, input logic [2:0] t, input logic [3:0] c,
                          input logic [6:0] a, input logic [6:0] b);
      chk({tag, "_valid"}, bus.evt_valid, 1);
      chk({tag, "_type"},  bus.evt_type,  t);
      chk({tag, "_chan"},  bus.evt_chan,  c);
      chk({tag, "_d1"},    bus.evt_d1,    a);
      chk({tag, "_d2"},    bus.evt_d2,    b);
   endtask

   initial begin
      logic [7:0] b;
      int         r;
      bus.rx_valid = 0; bus.rx_byte = 0; bus.evt_ready = 1; rst = 1;
      @(negedge clk);
      step(0, 8'h00, 1, 1);
      step(0, 8'h00, 1, 1);
      chk("rst_valid", bus.evt_valid, 0);
      chk("rst_ovf",   bus.overflow,  0);
      chk("rst_d1",    bus.evt_d1,    0);

      // note_on, three bytes
      send(8'h93, 1); send(8'h3C, 1);
      chk("non_early", bus.evt_valid, 0);
      send(8'h64, 1);
      chk_evt("non", 3'd1, 4'd3, 7'h3C, 7'h64);
      step(0, 8'h00, 1, 0);
      chk("non_fall", bus.evt_valid, 0);

      // running status with velocity-zero note_on
      send(8'h90, 1); send(8'h40, 1); send(8'h7F, 1);
      chk_evt("rs1", 3'd1, 4'd0, 7'h40, 7'h7F);
      send(8'h40, 1); send(8'h00, 1);
      chk_evt("rs2", 3'd0, 4'd0, 7'h40, 7'h00);

      // real-time interleave
      send(8'hB2, 1); send(8'hF8, 1); send(8'h07, 1); send(8'hFE, 1); send(8'h50, 1);
      chk_evt("rt", 3'd3, 4'd2, 7'h07, 7'h50);

      // program change and SysEx
      send(8'hC5, 1); send(8'h0A, 1);
      chk_evt("pc1", 3'd4, 4'd5, 7'h0A, 7'h00);
      send(8'h0B, 1);
      chk_evt("pc2", 3'd4, 4'd5, 7'h0B, 7'h00);
      send(8'hF0, 1); send(8'h01, 1); send(8'hF7, 1); send(8'h22, 1);
      chk("sysex_none", bus.evt_valid, 0);

      // backpressure
      step(0, 8'h00, 1, 1);
      send(8'h80, 0); send(8'h3C, 0); send(8'h40, 0);
      send(8'h80, 0); send(8'h3D, 0); send(8'h41, 0);
      chk_evt("bp", 3'd0, 4'd0, 7'h3C, 7'h40);
      chk("bp_ovf", bus.overflow, 1);
      step(0, 8'h00, 1, 0);
      chk("bp_fall", bus.evt_valid, 0);
      chk("bp_ovf_sticky", bus.overflow, 1);

      // reset mid-message
      send(8'h90, 1); send(8'h3C, 1);
      step(0, 8'h00, 1, 1);
      send(8'h45, 1);
      chk("rm_valid", bus.evt_valid, 0);
      chk("rm_ovf",   bus.overflow,  0);
      chk("rm_d2",    bus.evt_d2,    0);

      // random streams
      for (int i = 0; i < 4000; i++) begin
         r = $urandom_range(0, 99);
         if (r < 40)      b = 8'($urandom_range(8'h00, 8'h7F));
         else if (r < 65) b = 8'($urandom_range(8'h80, 8'hEF));
         else if (r < 75) b = 8'($urandom_range(8'hF8, 8'hFF));
         else if (r < 80) b = 8'hF0;
         else             b = 8'($urandom_range(8'hF1, 8'hF7));
         step(($urandom_range(0, 99) < 80), b, ($urandom_range(0, 99) < 60),
              ($urandom_range(0, 999) < 5));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
